// File: rtl/filter_buffer_if.sv
// Filter-buffer bus: weight stream from the loader plus the PE filter read port.
// master = loader/PE side, slave = filter_buffer.
interface filter_buffer_if #(
    parameter int unsigned FILTER_DW = 72,
    parameter int unsigned BUF_AW    = 9
);
    logic [FILTER_DW-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 fb_req;
    logic [BUF_AW-1:0]    fb_addr;
    logic [FILTER_DW-1:0] fb_data0_out;
    logic [FILTER_DW-1:0] fb_data1_out;
    logic [FILTER_DW-1:0] fb_data2_out;
    logic [FILTER_DW-1:0] fb_data3_out;

    modport master (
        output s_data, s_valid, fb_req, fb_addr,
        input  s_ready, fb_data0_out, fb_data1_out, fb_data2_out, fb_data3_out
    );

    modport slave (
        input  s_data, s_valid, fb_req, fb_addr,
        output s_ready, fb_data0_out, fb_data1_out, fb_data2_out, fb_data3_out
    );
endinterface

// File: rtl/filter_buffer.sv
// Ping-pong filter weight store: four banks read in parallel by the PE with 1-cycle latency,
// while the loader streams the next layer's weights into the half not being read.
module filter_buffer #(
    parameter int unsigned FILTER_DW = 72,
    parameter int unsigned BUF_AW    = 9,
    parameter int unsigned NB_FILTER = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_load_start,
    input  logic [BUF_AW:0]   i_load_len,
    output logic              o_load_busy,
    output logic              o_load_done,
    output logic              o_err,
    input  logic              i_swap,
    output logic              o_rd_half,
    filter_buffer_if.slave    bus
);

    localparam int unsigned MemDepth = 2 ** (BUF_AW + 1);
    localparam logic [BUF_AW:0] LenMax = {1'b1, {BUF_AW{1'b0}}};

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e               state_q, state_d;
    logic [BUF_AW:0]      len_q, len_d;
    logic [BUF_AW-1:0]    addr_q, addr_d;
    logic [1:0]           bank_q, bank_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 half_q, half_d;
    logic                 pend_q, pend_d;
    logic                 wr_en;
    logic [FILTER_DW-1:0] data_q [NB_FILTER];

    // Half select is the MSB of each bank's address, so read and write never collide.
    logic [FILTER_DW-1:0] mem [NB_FILTER][MemDepth];

    assign wr_en = (state_q == StLoad) && bus.s_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        err_d   = err_q;
        half_d  = half_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (i_swap) half_d = ~half_q;
                if (i_load_start) begin
                    if (i_load_len == '0) begin
                        done_d = 1'b1;
                    end else if (i_load_len > LenMax) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                        len_d   = i_load_len;
                        addr_d  = '0;
                        bank_d  = '0;
                    end
                end
            end
            StLoad: begin
                if (i_swap) pend_d = 1'b1;
                if (bus.s_valid) begin
                    bank_d = bank_q + 2'd1;
                    if (bank_q == 2'd3) begin
                        addr_d = addr_q + 1'b1;
                        if ({1'b0, addr_q} == len_q - 1'b1) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            pend_d  = 1'b0;
                            // A swap requested during the load lands together with done.
                            if (pend_q || i_swap) half_d = ~half_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            len_q   <= '0;
            addr_q  <= '0;
            bank_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            half_q  <= 1'b0;
            pend_q  <= 1'b0;
            for (int n = 0; n < NB_FILTER; n++) data_q[n] <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            err_q   <= err_d;
            half_q  <= half_d;
            pend_q  <= pend_d;
            if (bus.fb_req) begin
                for (int n = 0; n < NB_FILTER; n++) data_q[n] <= mem[n][{half_q, bus.fb_addr}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[bank_q][{~half_q, addr_q}] <= bus.s_data;
    end

    assign bus.s_ready      = (state_q == StLoad);
    assign o_load_busy      = (state_q == StLoad);
    assign o_load_done      = done_q;
    assign o_err            = err_q;
    assign o_rd_half        = half_q;
    assign bus.fb_data0_out = data_q[0];
    assign bus.fb_data1_out = data_q[1];
    assign bus.fb_data2_out = data_q[2];
    assign bus.fb_data3_out = data_q[3];

endmodule

// File: tb/tb_filter_buffer.sv
// Directed bench for filter_buffer: load/swap/read sequences with hand-computed expectations.
module tb_filter_buffer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_load_start;
    logic [9:0] i_load_len;
    logic       i_swap;
    logic       o_load_busy;
    logic       o_load_done;
    logic       o_err;
    logic       o_rd_half;
    int         checks = 0;
    int         failures = 0;

    filter_buffer_if #(.FILTER_DW(72), .BUF_AW(9)) bus ();

    filter_buffer #(.FILTER_DW(72), .BUF_AW(9), .NB_FILTER(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_load_start (i_load_start),
        .i_load_len   (i_load_len),
        .o_load_busy  (o_load_busy),
        .o_load_done  (o_load_done),
        .o_err        (o_err),
        .i_swap       (i_swap),
        .o_rd_half    (o_rd_half),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [8:0] addr, input logic [71:0] e0, input logic [71:0] e1,
                      input logic [71:0] e2, input logic [71:0] e3);
        bus.fb_req  = 1'b1;
        bus.fb_addr = addr;
        tick();
        bus.fb_req  = 1'b0;
        check("rd_data0", bus.fb_data0_out, e0);
        check("rd_data1", bus.fb_data1_out, e1);
        check("rd_data2", bus.fb_data2_out, e2);
        check("rd_data3", bus.fb_data3_out, e3);
    endtask

    // Streams 4*len words base+i back to back; optionally checks the held read of bank 0.
    task automatic do_load(input int len, input logic [71:0] base, input int swap_at,
                           input bit swap_start, input bit chk_rd, input logic [71:0] exp_rd);
        logic h0;
        i_load_start = 1'b1;
        i_load_len   = 10'(len);
        i_swap       = swap_start;
        tick();
        i_load_start = 1'b0;
        i_swap       = 1'b0;
        h0 = o_rd_half;
        check("busy_after_start", 72'(o_load_busy), 72'd1);
        check("ready_after_start", 72'(bus.s_ready), 72'd1);
        for (int i = 0; i < 4 * len; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = base + 72'(i);
            i_swap      = (i == swap_at);
            tick();
            if (chk_rd) check("rd_during_load", bus.fb_data0_out, exp_rd);
            if (chk_rd && i < 4 * len - 1) check("rd_half_hold", 72'(o_rd_half), 72'(h0));
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        i_swap      = 1'b0;
        check("done_pulse", 72'(o_load_done), 72'd1);
        check("busy_end", 72'(o_load_busy), 72'd0);
        check("ready_end", 72'(bus.s_ready), 72'd0);
    endtask

    initial begin
        int busy_cnt;
        rstn         = 1'b0;
        i_load_start = 1'b0;
        i_load_len   = '0;
        i_swap       = 1'b0;
        bus.s_data   = '0;
        bus.s_valid  = 1'b0;
        bus.fb_req   = 1'b0;
        bus.fb_addr  = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("rst_ready", 72'(bus.s_ready), 72'd0);
        check("rst_busy", 72'(o_load_busy), 72'd0);
        check("rst_done", 72'(o_load_done), 72'd0);
        check("rst_err", 72'(o_err), 72'd0);
        check("rst_half", 72'(o_rd_half), 72'd0);
        check("rst_data0", bus.fb_data0_out, 72'd0);

        // Basic load of half 1, swap, read back both addresses.
        do_load(2, 72'h10, -1, 1'b0, 1'b0, 72'd0);
        tick();
        check("done_single", 72'(o_load_done), 72'd0);
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        check("swap_idle", 72'(o_rd_half), 72'd1);
        rd(9'd0, 72'h10, 72'h11, 72'h12, 72'h13);
        rd(9'd1, 72'h14, 72'h15, 72'h16, 72'h17);
        tick();
        check("rd_hold", bus.fb_data0_out, 72'h14);

        // Stalling stream: valid every other cycle, junk on invalid beats.
        i_load_start = 1'b1;
        i_load_len   = 10'd1;
        tick();
        i_load_start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            bus.s_valid = c[0];
            bus.s_data  = c[0] ? 72'h20 + 72'(c / 2) : 72'hFF;
            if (o_load_busy) busy_cnt++;
            tick();
        end
        bus.s_valid = 1'b0;
        check("stall_done", 72'(o_load_done), 72'd1);
        check("stall_busy_end", 72'(o_load_busy), 72'd0);
        check("stall_busy_cycles", 72'(busy_cnt), 72'd8);
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        check("stall_swap", 72'(o_rd_half), 72'd0);
        rd(9'd0, 72'h20, 72'h21, 72'h22, 72'h23);

        // Read half 1 (addr5 bank0 = 0xAA) while loading half 0 (addr5 bank0 = 0xBB).
        do_load(6, 72'h96, -1, 1'b0, 1'b0, 72'd0);
        tick();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        check("pp_half1", 72'(o_rd_half), 72'd1);
        rd(9'd5, 72'hAA, 72'hAB, 72'hAC, 72'hAD);
        bus.fb_req  = 1'b1;
        bus.fb_addr = 9'd5;
        do_load(6, 72'hA7, 10, 1'b0, 1'b1, 72'hAA);
        check("pend_swap_on_done", 72'(o_rd_half), 72'd0);
        tick();
        bus.fb_req = 1'b0;
        check("rd_new_half", bus.fb_data0_out, 72'hBB);
        check("rd_new_half_b3", bus.fb_data3_out, 72'hBE);

        // Zero length and over-length starts.
        i_load_start = 1'b1;
        i_load_len   = 10'd0;
        tick();
        i_load_start = 1'b0;
        check("len0_done", 72'(o_load_done), 72'd1);
        check("len0_ready", 72'(bus.s_ready), 72'd0);
        check("len0_busy", 72'(o_load_busy), 72'd0);
        tick();
        check("len0_done_clr", 72'(o_load_done), 72'd0);
        check("len0_ready2", 72'(bus.s_ready), 72'd0);
        i_load_start = 1'b1;
        i_load_len   = 10'd513;
        tick();
        i_load_start = 1'b0;
        check("ovf_err", 72'(o_err), 72'd1);
        check("ovf_busy", 72'(o_load_busy), 72'd0);
        check("ovf_nodone", 72'(o_load_done), 72'd0);
        tick();
        check("ovf_busy2", 72'(o_load_busy), 72'd0);
        do_load(1, 72'h30, -1, 1'b0, 1'b0, 72'd0);
        check("err_sticky", 72'(o_err), 72'd1);
        tick();

        // Swap and start in one cycle: load must target the previously read half (0).
        do_load(1, 72'h40, -1, 1'b1, 1'b0, 72'd0);
        check("swap_start_half", 72'(o_rd_half), 72'd1);
        tick();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        check("swap_back", 72'(o_rd_half), 72'd0);
        rd(9'd0, 72'h40, 72'h41, 72'h42, 72'h43);

        // Reset in the middle of a load.
        i_load_start = 1'b1;
        i_load_len   = 10'd2;
        tick();
        i_load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 72'h60 + 72'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", 72'(o_load_busy), 72'd0);
        check("mid_rst_ready", 72'(bus.s_ready), 72'd0);
        check("mid_rst_done", 72'(o_load_done), 72'd0);
        check("mid_rst_err", 72'(o_err), 72'd0);
        check("mid_rst_half", 72'(o_rd_half), 72'd0);
        check("mid_rst_data0", bus.fb_data0_out, 72'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_busy", 72'(o_load_busy), 72'd0);
        do_load(1, 72'h50, -1, 1'b0, 1'b0, 72'd0);
        tick();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        rd(9'd0, 72'h50, 72'h51, 72'h52, 72'h53);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_buffer.md
Name: filter_buffer

Overview:
- Double-buffered (ping-pong) filter weight store that answers the PE engine's filter read port.
- Receives `o_fb_req`/`o_fb_addr` from the PE engine and returns four bank words (one per output channel, Tout=4) with 1-cycle latency. This matches the engine's BUF_DELAY=1.
- The write side accepts a valid/ready weight stream from the DMA/loader into the half not being read. The next layer's filters therefore load while the current layer computes.

Parameters:
- FILTER_DW, 72, width of one filter word (K*K weights of 8 bit each, K=3).
- BUF_AW, 9, read/write address width; depth per half = 2^BUF_AW words per bank.
- NB_FILTER, 4, number of banks (= Tout); fixed at 4 in this block.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_load_start  in  1  start-load pulse
- i_load_len  in  BUF_AW+1  number of addresses to load (each address = 4 stream words)
- s_data  in  FILTER_DW  weight stream data
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- o_load_busy  out  1  high while in LOAD
- o_load_done  out  1  1-cycle pulse when load completes
- o_err  out  1  sticky error flag, cleared only by reset
- i_swap  in  1  request to exchange read and write halves
- o_rd_half  out  1  half currently served to the PE
- fb_req  in  1  PE read request
- fb_addr  in  BUF_AW  PE read address
- fb_data0_out .. fb_data3_out  out  FILTER_DW each  bank 0..3 read data

Behaviour:
- Reset values: all outputs are 0 (s_ready, o_load_busy, o_load_done, o_err, o_rd_half, fb_data*_out). FSM = IDLE. Pending-swap flag = 0. Memory contents are undefined.
- Storage: 2 halves x 4 banks x 2^BUF_AW words. The write half is always ~o_rd_half, so read and write never address the same physical word.
- FSM states: IDLE, LOAD.
- IDLE behaviour:
  - i_load_start with 1 <= i_load_len <= 2^BUF_AW: latch the length, set addr=0, bank=0, go to LOAD.
  - i_load_len == 0: o_load_done pulses the next cycle and the FSM stays in IDLE.
  - i_load_len > 2^BUF_AW: o_err sets, the start is ignored and the FSM stays in IDLE.
- LOAD behaviour:
  - s_ready = 1 and o_load_busy = 1, both registered and asserted the cycle after the start.
  - On each s_valid && s_ready: write s_data to bank[bank] of the write half at addr. Then increment bank; on bank==3, wrap bank to 0 and increment addr.
  - The handshake with addr==len-1 and bank==3 is the last word. The next cycle: FSM = IDLE, s_ready = 0, o_load_busy = 0, o_load_done = 1 for exactly one cycle.
  - s_valid low stalls the counters; there is no timeout.
  - i_load_start received during LOAD is ignored and does not set o_err.
- Swap behaviour:
  - i_swap in IDLE: o_rd_half toggles the next cycle.
  - i_swap during LOAD: sets the pending flag and does not change o_rd_half. The pending swap applies in the same cycle the o_load_done pulse appears (o_rd_half toggles then), and the flag clears. Multiple requests collapse into one.
  - i_swap and i_load_start in the same IDLE cycle: the swap takes effect first. The load targets ~(new o_rd_half), i.e. the half that was being read before the swap.
- Read path:
  - fb_req=1 at cycle t with fb_addr=A: at t+1, fb_dataN_out = bank N[o_rd_half at t][A].
  - fb_req=0: outputs hold their previous value.
  - Reads continue unaffected during LOAD.
- Reset mid-LOAD: returns to IDLE with all outputs at reset values. The partially written half is invalid and must be reloaded.

Test Plan:
- Load len=2 with stream words 0x10..0x17, then i_swap. Read fb_addr=0 and 1 -> after 1 cycle, data0..3 = 0x10,0x11,0x12,0x13, then 0x14..0x17. o_load_done pulses once, 1 cycle after the 8th handshake.
- Stream with s_valid toggling every other cycle for len=1 -> exactly 4 writes; o_load_busy stays high 8 cycles; no word is lost or duplicated.
- While reading half 0 (addr=5 with known value 0xAA in bank0), load half 1 with addr5=0xBB -> reads return 0xAA throughout the load. Issue i_swap during LOAD -> o_rd_half flips on the o_load_done cycle; the next read of addr5 returns 0xBB.
- i_load_len=0 -> o_load_done pulse after 1 cycle; s_ready is never asserted. i_load_len=2^BUF_AW+1 -> o_err=1, no LOAD. A following valid load still works and o_err remains 1.
- i_swap and i_load_start in the same cycle with o_rd_half=0 -> o_rd_half=1 and the load writes half 0.
- Assert rstn low mid-LOAD after 3 words -> all outputs 0, FSM IDLE. A new load of len=1 completes normally.
